// File: rtl/pool_seq_ctrl.sv
// Frame sequencer for a combinational 2x2 max-pool: collects a conv map from a byte stream, lets the
// pool datapath settle, captures it and streams the pooled bytes out; no input accepted while busy.
module pool_seq_ctrl #(
   parameter int DW     = 8,
   parameter int N_IN   = 108,
   parameter int N_OUT  = 27,
   parameter int SETTLE = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DW-1:0]       in_data,
   input  logic                in_valid,
   input  logic                in_last,
   output logic                in_ready,
   output logic [N_IN*DW-1:0]  conv_lin,
   input  logic [N_OUT*DW-1:0] pool_lin,
   output logic [DW-1:0]       out_data,
   output logic                out_valid,
   output logic                out_last,
   input  logic                out_ready,
   output logic                busy,
   output logic                frame_done,
   output logic                frame_err,
   output logic [7:0]          frame_cnt
);

   localparam int WW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [6:0]    IN_END   = 7'(N_IN - 1);
   localparam logic [4:0]    OUT_END  = 5'(N_OUT - 1);
   localparam logic [WW-1:0] SETTLE_V = WW'(SETTLE);

   typedef enum logic [1:0] {S_LOAD, S_WAIT, S_OUT} state_t;

   state_t               state, state_nx;
   logic [6:0]           in_cnt;
   logic [4:0]           out_cnt;
   logic [WW-1:0]        wait_cnt;
   logic                 armed;
   logic [N_OUT*DW-1:0]  result;
   logic                 in_fire, out_fire, in_at_end, out_at_end, settle_done;

   assign in_fire     = in_valid & in_ready;
   assign out_fire    = out_valid & out_ready;
   assign in_at_end   = (in_cnt == IN_END);
   assign out_at_end  = (out_cnt == OUT_END);
   assign settle_done = (state == S_WAIT) && (wait_cnt == SETTLE_V);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_LOAD;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_LOAD:  if (in_fire && in_at_end)   state_nx = S_WAIT;
         S_WAIT:  if (settle_done)            state_nx = S_OUT;
         S_OUT:   if (out_fire && out_at_end) state_nx = S_LOAD;
         default:                             state_nx = S_LOAD;
      endcase
   end

   // armed keeps in_ready low for the whole reset, even though state already reads LOAD
   always_comb begin
      in_ready  = armed && (state == S_LOAD);
      out_valid = (state == S_OUT);
      busy      = (state == S_WAIT) || (state == S_OUT);
      out_last  = (state == S_OUT) && out_at_end;
      out_data  = '0;
      for (int j = 0; j < N_OUT; j++) begin
         if (out_cnt == 5'(j)) out_data = result[j*DW +: DW];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         armed      <= 1'b0;
         in_cnt     <= '0;
         out_cnt    <= '0;
         wait_cnt   <= '0;
         conv_lin   <= '0;
         result     <= '0;
         frame_cnt  <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         armed      <= 1'b1;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;

         if (in_fire) begin
            for (int i = 0; i < N_IN; i++) begin
               if (in_cnt == 7'(i)) conv_lin[i*DW +: DW] <= in_data;
            end
            // a full count always closes the frame; a missing in_last is only flagged
            if (in_at_end) begin
               in_cnt    <= '0;
               frame_err <= ~in_last;
            end else if (in_last) begin
               in_cnt    <= '0;
               frame_err <= 1'b1;
            end else begin
               in_cnt <= in_cnt + 7'd1;
            end
         end

         if (state == S_WAIT) begin
            if (settle_done) begin
               wait_cnt <= '0;
               result   <= pool_lin;
            end else begin
               wait_cnt <= wait_cnt + WW'(1);
            end
         end

         if (out_fire) begin
            if (out_at_end) begin
               out_cnt    <= '0;
               frame_done <= 1'b1;
               frame_cnt  <= frame_cnt + 8'd1;
            end else begin
               out_cnt <= out_cnt + 5'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Bench for pool_seq_ctrl: random frames through a behavioural max-pool environment, scoreboard
// of expected pooled bytes checked by an independent output monitor.
`timescale 1ns/1ps
module tb_pool_seq_ctrl;
   localparam int DW = 8, N_IN = 108, N_OUT = 27, SETTLE = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [DW-1:0]       in_data;
   logic                in_valid, in_last, in_ready;
   logic [N_IN*DW-1:0]  conv_lin;
   logic [N_OUT*DW-1:0] pool_lin, junk;
   logic [DW-1:0]       out_data;
   logic                out_valid, out_last, out_ready, busy, frame_done, frame_err;
   logic [7:0]          frame_cnt;

   pool_seq_ctrl #(.DW(DW), .N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .conv_lin(conv_lin), .pool_lin(pool_lin),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [7:0] d; logic l; } exp_t;
   exp_t       exp_q[$];
   logic [7:0] frm [N_IN];
   int n_tests = 0, n_fail = 0;
   int cyc = 0, t_last = 0, n_pop = 0, model_cnt = 0, n_full = 0, rdy_pct = 100;
   bit lat_arm = 0, err_due = 0, done_due = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic abort(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out", name);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   endtask

   // Pool datapath environment: every input element folds into the max of its 2x2 window.
   function automatic logic [N_OUT*DW-1:0] pool_env(input logic [N_IN*DW-1:0] c);
      logic [N_OUT*DW-1:0] p;
      int ch, r, col, j;
      p = '0;
      for (int i = 0; i < N_IN; i++) begin
         ch = i / 36; r = (i % 36) / 6; col = i % 6;
         j = ch*9 + (r/2)*3 + col/2;
         if (c[i*DW +: DW] > p[j*DW +: DW]) p[j*DW +: DW] = c[i*DW +: DW];
      end
      return p;
   endfunction

   // While the DUT streams out, the datapath output is scrambled: the captured copy must not care.
   always_comb pool_lin = pool_env(conv_lin) ^ (out_valid ? junk : '0);

   initial begin
      logic [223:0] tmp;
      junk = '0;
      forever begin
         @(negedge clk);
         tmp  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         junk = tmp[N_OUT*DW-1:0];
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         out_ready = (int'($urandom_range(99)) < rdy_pct);
      end
   end

   function automatic void push_expected();
      logic [7:0] m, v;
      for (int ch = 0; ch < 3; ch++)
         for (int pr = 0; pr < 3; pr++)
            for (int pc = 0; pc < 3; pc++) begin
               m = '0;
               for (int k = 0; k < 4; k++) begin
                  v = frm[ch*36 + (2*pr + k/2)*6 + 2*pc + k%2];
                  if (v > m) m = v;
               end
               exp_q.push_back('{d: m, l: (ch == 2 && pr == 2 && pc == 2)});
            end
   endfunction

   task automatic send_byte(input logic [7:0] d, input logic l, input int gap_pct);
      int gap, w;
      gap = (int'($urandom_range(99)) < gap_pct) ? int'($urandom_range(3, 1)) : 0;
      w = 0;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #2; end
      in_valid = 1'b1; in_data = d; in_last = l;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         w++;
         if (w > 3000) abort("in_ready_wait");
         @(posedge clk); #2;
      end
      @(posedge clk); #2;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // last_at: index carrying in_last (-1: never asserted)
   task automatic send_frame(input int last_at, input int gap_pct);
      int n;
      n = (last_at >= 0) ? last_at + 1 : N_IN;
      if (n == N_IN) push_expected();
      for (int i = 0; i < n; i++) begin
         send_byte(frm[i], (i == last_at), gap_pct);
         if (i == N_IN - 1) begin t_last = cyc; lat_arm = 1; n_full++; end
         if ((i == last_at && i != N_IN - 1) || (i == N_IN - 1 && last_at != N_IN - 1)) err_due = 1;
      end
   endtask

   task automatic rand_frame();
      for (int i = 0; i < N_IN; i++) frm[i] = 8'($urandom);
   endtask

   task automatic drain(input string name);
      int w;
      w = 0;
      while (exp_q.size() != 0 || out_valid || busy) begin
         @(posedge clk); #2;
         w++;
         if (w > 5000) abort(name);
      end
      repeat (2) begin @(posedge clk); #2; end
   endtask

   // Output monitor / scoreboard
   initial begin
      logic prev_stall, prev_l;
      logic [7:0] prev_d;
      exp_t e;
      prev_stall = 0; prev_l = 0; prev_d = 0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            prev_stall = 0; lat_arm = 0; err_due = 0; done_due = 0;
         end else begin
            if (done_due) begin
               chk("frame_done_pulse", frame_done, 1);
               chk("frame_cnt", frame_cnt, model_cnt[7:0]);
               done_due = 0;
            end else begin
               chk("frame_done_idle", frame_done, 0);
            end
            chk("frame_err", frame_err, err_due);
            err_due = 0;
            if (prev_stall) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_data", out_data, prev_d);
               chk("hold_last", out_last, prev_l);
            end
            if (lat_arm && out_valid) begin
               chk("latency", cyc - t_last, SETTLE + 1);
               lat_arm = 0;
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("extra_output", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", out_data, e.d);
                  chk("out_last", out_last, e.l);
                  n_pop++;
                  if (e.l) begin model_cnt++; done_due = 1; end
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
         end
      end
   end

   initial begin
      int base, w;
      rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b1;

      // T1: reset with in_valid held high
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_last", out_last, 0);
         chk("rst_out_data", out_data, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done_err", {frame_done, frame_err}, 0);
         chk("rst_frame_cnt", frame_cnt, 0);
         chk("rst_conv_lin", |conv_lin, 0);
      end
      @(posedge clk); #2;
      rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1);

      // T2: ramp frame, no stalls
      for (int i = 0; i < N_IN; i++) frm[i] = 8'(i);
      @(posedge clk); #2;
      send_frame(N_IN - 1, 0);
      drain("t2_drain");
      chk("t2_frame_cnt", frame_cnt, 1);

      // T3: output backpressure
      rdy_pct = 50;
      rand_frame();
      base = n_pop;
      send_frame(N_IN - 1, 0);
      drain("t3_drain");
      chk("t3_xfers", n_pop - base, N_OUT);

      // T4: framing errors
      rdy_pct = 70;
      rand_frame();
      base = n_pop;
      send_frame(50, 30);
      drain("t4_drop_drain");
      chk("t4_drop_no_output", n_pop - base, 0);
      rand_frame();
      send_frame(N_IN - 1, 30);
      drain("t4_good_drain");
      rand_frame();
      send_frame(-1, 30);
      drain("t4_nolast_drain");
      chk("t4_xfers", n_pop - base, 2 * N_OUT);

      // T5: 100 random frames back to back with random handshakes
      rdy_pct = 60;
      base = n_pop;
      for (int f = 0; f < 100; f++) begin
         rand_frame();
         send_frame(N_IN - 1, 25);
      end
      drain("t5_drain");
      chk("t5_xfers", n_pop - base, 100 * N_OUT);

      // frame counter wrap
      rdy_pct = 100;
      while (n_full < 256) begin
         rand_frame();
         send_frame(N_IN - 1, 0);
      end
      drain("wrap_drain");
      chk("wrap_frame_cnt", frame_cnt, 0);

      // T6: reset after 10 output bytes
      rdy_pct = 100;
      rand_frame();
      base = n_pop;
      send_frame(N_IN - 1, 0);
      w = 0;
      while (n_pop < base + 10) begin
         @(posedge clk); #2;
         w++;
         if (w > 500) abort("t6_wait_out");
      end
      rst_n = 1'b0;
      exp_q.delete();
      model_cnt = 0;
      n_full = 0;
      @(posedge clk); @(negedge clk);
      chk("t6_out_valid", out_valid, 0);
      chk("t6_frame_cnt", frame_cnt, 0);
      chk("t6_no_done", frame_done, 0);
      chk("t6_busy", busy, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
      rdy_pct = 50;
      rand_frame();
      base = n_pop;
      send_frame(N_IN - 1, 30);
      drain("t6_drain");
      chk("t6_xfers", n_pop - base, N_OUT);
      chk("t6_frame_cnt_after", frame_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
